// File: rtl/instr_sequencer.sv
// Instruction sequencer: latches an instruction word on start, decodes it and
// walks the datapath control states, counting retired legal instructions.
module instr_sequencer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s,
  input  logic [15:0]          in,
  output logic [3:0]           state,
  output logic                 w,
  output logic                 done,
  output logic                 illegal,
  output logic [2:0]           rn,
  output logic [2:0]           rd,
  output logic [2:0]           rm,
  output logic [1:0]           shift,
  output logic [15:0]          sximm8,
  output logic [2:0]           wnum,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned IR_W = 16;

  typedef enum logic [3:0] {
    S_WAIT      = 4'b0000,
    S_DECODE    = 4'b0001,
    S_WRITE_IMM = 4'b0010,
    S_LOAD_AB   = 4'b0011,
    S_LOAD_B    = 4'b0100,
    S_LOAD_C    = 4'b0101,
    S_WRITE_C   = 4'b0110,
    S_LOAD_S    = 4'b0111
  } state_t;

  state_t            st;
  logic [IR_W-1:0]   ir;
  state_t            dec_nxt;
  logic              dec_illegal;
  logic              dec_cmp;
  logic [CNT_WIDTH-1:0] count_inc;

  // Register fields come straight from the latched instruction.
  assign state  = st;
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // Saturating increment of the retired-instruction counter.
  assign count_inc = (count == {CNT_WIDTH{1'b1}}) ? count : count + CNT_WIDTH'(1);

  // Decode opcode/op into the first execution state after S_DECODE.
  always_comb begin
    dec_nxt     = S_WAIT;
    dec_illegal = 1'b0;
    dec_cmp     = 1'b0;
    case ({ir[15:13], ir[12:11]})
      5'b110_10:            dec_nxt = S_WRITE_IMM;
      5'b110_00, 5'b101_11: dec_nxt = S_LOAD_B;
      5'b101_00, 5'b101_10: dec_nxt = S_LOAD_AB;
      5'b101_01: begin
        dec_nxt = S_LOAD_AB;
        dec_cmp = 1'b1;
      end
      default:              dec_illegal = 1'b1;
    endcase
  end

  // Sequencer state, instruction register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= S_WAIT;
      ir      <= '0;
      w       <= 1'b1;
      done    <= 1'b0;
      illegal <= 1'b0;
      wnum    <= 3'b000;
      count   <= '0;
    end else begin
      done <= 1'b0;
      wnum <= 3'b000;
      w    <= 1'b0;
      case (st)
        S_WAIT: begin
          if (s) begin
            ir      <= in;
            illegal <= 1'b0;
            st      <= S_DECODE;
          end else begin
            w <= 1'b1;
          end
        end
        S_DECODE: begin
          st <= dec_nxt;
          if (dec_illegal) begin
            illegal <= 1'b1;
            done    <= 1'b1;
            w       <= 1'b1;
          end else if (dec_nxt == S_WRITE_IMM) begin
            wnum <= ir[10:8];
          end
        end
        S_LOAD_AB: st <= dec_cmp ? S_LOAD_S : S_LOAD_C;
        S_LOAD_B:  st <= S_LOAD_C;
        S_LOAD_C: begin
          st   <= S_WRITE_C;
          wnum <= ir[7:5];
        end
        S_WRITE_IMM, S_WRITE_C, S_LOAD_S: begin
          st    <= S_WAIT;
          done  <= 1'b1;
          w     <= 1'b1;
          count <= count_inc;
        end
        // Unused codes fall back to idle silently.
        default: begin
          st <= S_WAIT;
          w  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-instruction expected state
// traces are queued on issue and compared cycle by cycle.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] in;

  logic [3:0]  state, state4;
  logic        w, w4, done, done4, illegal, illegal4;
  logic [2:0]  rn, rd, rm, rn4, rd4, rm4, wnum, wnum4;
  logic [1:0]  shift, shift4;
  logic [15:0] sximm8, sximm84;
  logic [15:0] count;
  logic [3:0]  count4;

  instr_sequencer #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in), .state(state), .w(w),
    .done(done), .illegal(illegal), .rn(rn), .rd(rd), .rm(rm), .shift(shift),
    .sximm8(sximm8), .wnum(wnum), .count(count)
  );

  instr_sequencer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in), .state(state4), .w(w4),
    .done(done4), .illegal(illegal4), .rn(rn4), .rd(rd4), .rm(rm4), .shift(shift4),
    .sximm8(sximm84), .wnum(wnum4), .count(count4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] wn;
    logic       dn;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_cnt  = 16'd0;
  logic [3:0]  model_cnt4 = 4'd0;
  logic        model_ill  = 1'b0;

  // Build the expected per-cycle trace of one instruction after its accept edge.
  task automatic push_expect(input logic [15:0] instr);
    logic [3:0] path[$];
    exp_t       e;
    path.push_back(4'd1);
    case ({instr[15:13], instr[12:11]})
      5'b11010: path.push_back(4'd2);
      5'b11000, 5'b10111: begin path.push_back(4'd4); path.push_back(4'd5); path.push_back(4'd6); end
      5'b10100, 5'b10110: begin path.push_back(4'd3); path.push_back(4'd5); path.push_back(4'd6); end
      5'b10101: begin path.push_back(4'd3); path.push_back(4'd7); end
      default: ;
    endcase
    foreach (path[i]) begin
      e.st = path[i];
      e.wn = (path[i] == 4'd2) ? instr[10:8] : (path[i] == 4'd6) ? instr[7:5] : 3'd0;
      e.dn = 1'b0;
      exp_q.push_back(e);
    end
    e.st = 4'd0; e.wn = 3'd0; e.dn = 1'b1;
    exp_q.push_back(e);
  endtask

  // Follow one accepted instruction to completion; optionally chain the next start.
  task automatic run(input logic [15:0] instr, input bit noise, input bit chain,
                     input logic [15:0] nxt, input string name);
    exp_t e;
    bit   legal;
    int   k = 0;
    push_expect(instr);
    legal = (exp_q.size() > 2);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || state4 !== e.st) begin
        errors++;
        $display("FAIL %s state c%0d: got %0d/%0d expected %0d", name, k, state, state4, e.st);
      end
      checks++;
      if (wnum !== e.wn || wnum4 !== e.wn) begin
        errors++;
        $display("FAIL %s wnum c%0d: got %0d/%0d expected %0d", name, k, wnum, wnum4, e.wn);
      end
      checks++;
      if (done !== e.dn || done4 !== e.dn) begin
        errors++;
        $display("FAIL %s done c%0d: got %b/%b expected %b", name, k, done, done4, e.dn);
      end
      checks++;
      if (w !== (e.st == 4'd0) || w4 !== (e.st == 4'd0)) begin
        errors++;
        $display("FAIL %s w c%0d: got %b/%b expected %b", name, k, w, w4, (e.st == 4'd0));
      end
      if (k == 0) begin
        checks++;
        if (rn !== instr[10:8] || rd !== instr[7:5] || rm !== instr[2:0] || shift !== instr[4:3]) begin
          errors++;
          $display("FAIL %s fields: got rn%0d rd%0d rm%0d sh%0d expected rn%0d rd%0d rm%0d sh%0d",
                   name, rn, rd, rm, shift, instr[10:8], instr[7:5], instr[2:0], instr[4:3]);
        end
        checks++;
        if (sximm8 !== {{8{instr[7]}}, instr[7:0]}) begin
          errors++;
          $display("FAIL %s sximm8: got %h expected %h", name, sximm8, {{8{instr[7]}}, instr[7:0]});
        end
        checks++;
        if ({rn4, rd4, rm4, shift4, sximm84} !== {rn, rd, rm, shift, sximm8}) begin
          errors++;
          $display("FAIL %s fields4: got %h expected %h", name,
                   {rn4, rd4, rm4, shift4, sximm84}, {rn, rd, rm, shift, sximm8});
        end
        checks++;
        if (illegal !== 1'b0 || illegal4 !== 1'b0) begin
          errors++;
          $display("FAIL %s illegal clear on accept: got %b/%b expected 0", name, illegal, illegal4);
        end
      end
      if (exp_q.size() == 0) begin
        if (legal) begin
          if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
          if (model_cnt4 != 4'hF) model_cnt4 = model_cnt4 + 4'd1;
        end
        model_ill = !legal;
        checks++;
        if (illegal !== model_ill || illegal4 !== model_ill) begin
          errors++;
          $display("FAIL %s illegal: got %b/%b expected %b", name, illegal, illegal4, model_ill);
        end
        checks++;
        if (count !== model_cnt || count4 !== model_cnt4) begin
          errors++;
          $display("FAIL %s count: got %0d/%0d expected %0d/%0d", name, count, count4, model_cnt, model_cnt4);
        end
        s  = chain;
        in = chain ? nxt : 16'h0000;
      end else if (noise) begin
        s  = 1'($urandom);
        in = 16'($urandom);
      end else begin
        s = 1'b0;
      end
      k++;
    end
  endtask

  task automatic issue(input logic [15:0] instr);
    @(negedge clk);
    s  = 1'b1;
    in = instr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s = 1'b1; in = 16'hFFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 4'd0 || w !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 ||
        count !== 16'd0 || wnum !== 3'd0 || sximm8 !== 16'h0000 || count4 !== 4'd0) begin
      errors++;
      $display("FAIL reset: got st%0d w%b d%b il%b cnt%0d wn%0d imm%h expected st0 w1 d0 il0 cnt0 wn0 imm0000",
               state, w, done, illegal, count, wnum, sximm8);
    end
    // Release with a start pending so it is accepted on the very first edge.
    reset_n = 1'b1;
    in = 16'hD5F0;
  endtask

  task automatic test_mov_imm();
    run(16'hD5F0, 1'b0, 1'b0, 16'h0, "mov_imm");
    checks++;
    if (sximm8 !== 16'hFFF0) begin
      errors++;
      $display("FAIL mov_imm sximm8: got %h expected fff0", sximm8);
    end
  endtask

  task automatic test_add();
    issue(16'hA1A2);
    run(16'hA1A2, 1'b0, 1'b0, 16'h0, "add");
  endtask

  task automatic test_cmp();
    issue(16'hA902);
    run(16'hA902, 1'b0, 1'b0, 16'h0, "cmp");
  endtask

  task automatic test_illegal();
    issue(16'hE000);
    run(16'hE000, 1'b0, 1'b0, 16'h0, "illegal");
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1 || done !== 1'b0 || state !== 4'd0) begin
      errors++;
      $display("FAIL illegal hold: got il%b d%b st%0d expected il1 d0 st0", illegal, done, state);
    end
    s = 1'b1; in = 16'hB8E4;
    run(16'hB8E4, 1'b0, 1'b1, 16'h0000, "mvn_after_illegal");
    run(16'h0000, 1'b0, 1'b1, 16'hC0A3, "illegal_zero");
    run(16'hC0A3, 1'b0, 1'b0, 16'h0, "mov_reg");
  endtask

  task automatic test_back_to_back();
    issue(16'hD27F);
    run(16'hD27F, 1'b0, 1'b1, 16'hA1A2, "b2b_mov");
    run(16'hA1A2, 1'b0, 1'b1, 16'hA902, "b2b_add");
    run(16'hA902, 1'b0, 1'b1, 16'hB61D, "b2b_cmp");
    run(16'hB61D, 1'b0, 1'b0, 16'h0, "b2b_and");
  endtask

  task automatic test_busy_noise();
    issue(16'hA5C6);
    run(16'hA5C6, 1'b1, 1'b0, 16'h0, "noise_add");
    issue(16'hBFFB);
    run(16'hBFFB, 1'b1, 1'b0, 16'h0, "noise_mvn");
    issue(16'hAF3D);
    run(16'hAF3D, 1'b1, 1'b0, 16'h0, "noise_cmp");
  endtask

  task automatic test_reset_mid_add();
    issue(16'hA1A2);
    @(negedge clk); s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd5) begin
      errors++;
      $display("FAIL midreset pre: got st%0d expected 5", state);
    end
    reset_n = 1'b0;
    #1;
    model_cnt = 16'd0; model_cnt4 = 4'd0; model_ill = 1'b0;
    checks++;
    if (state !== 4'd0 || count !== 16'd0 || count4 !== 4'd0 || done !== 1'b0 || w !== 1'b1 || wnum !== 3'd0) begin
      errors++;
      $display("FAIL midreset async: got st%0d cnt%0d/%0d d%b w%b wn%0d expected st0 cnt0 d0 w1 wn0",
               state, count, count4, done, w, wnum);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || state !== 4'd0 || count !== 16'd0) begin
        errors++;
        $display("FAIL midreset after: got d%b st%0d cnt%0d expected d0 st0 cnt0", done, state, count);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] instr;
    for (int i = 0; i < 17; i++) begin
      instr = {5'b11010, 3'(i % 8), 8'(i * 37)};
      issue(instr);
      run(instr, 1'b0, 1'b0, 16'h0, "sat_mov");
    end
    checks++;
    if (count4 !== 4'hF || count !== 16'd17) begin
      errors++;
      $display("FAIL saturation: got %0d/%0d expected 15/17", count4, count);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_illegal();
    test_back_to_back();
    test_busy_noise();
    test_reset_mid_add();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
